// File: rtl/grid_game_if.sv
// Command/status bundle between a game front-end (master) and grid_game_ctrl (slave).
interface grid_game_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned AW = $clog2(N*N);

  logic          new_game;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic          place;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;
  logic [AW-1:0] cursor;
  logic          turn;
  logic          busy;
  logic          place_err;
  logic [1:0]    winner;
  logic          game_over;

  modport master (
    output new_game, move_valid, move_dir, place, rd_addr,
    input  rd_data, cursor, turn, busy, place_err, winner, game_over
  );

  modport slave (
    input  new_game, move_valid, move_dir, place, rd_addr,
    output rd_data, cursor, turn, busy, place_err, winner, game_over
  );
endinterface

// File: rtl/grid_game_ctrl.sv
// Two-player N x N grid game controller: cursor, placement, fixed-latency
// K-in-a-row win/draw detection by walking outward from the placed cell.
module grid_game_ctrl #(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3
) (
  input  logic        clk,
  input  logic        resetn,
  grid_game_if.slave  bus
);
  localparam int unsigned CELLS = N*N;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned MW    = $clog2(CELLS+1);
  localparam int unsigned SW    = $clog2(K);
  localparam int unsigned CW    = $clog2(2*K);

  localparam logic [1:0] D_0 = 2'd0;
  localparam logic [1:0] D_P = 2'd1;
  localparam logic [1:0] D_M = 2'd2;

  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

  state_t               r_state, w_state_nxt;
  logic [CELLS-1:0][1:0] r_board;
  logic [RW-1:0]        r_row, r_col;
  logic                 r_turn;
  logic [MW-1:0]        r_moves;
  logic [1:0]           r_winner;
  logic                 r_busy, r_place_err, r_game_over;

  // check walker state
  logic [1:0]           r_mark;
  logic [RW-1:0]        r_pr, r_pc, r_wr, r_wc;
  logic [1:0]           r_axis;
  logic                 r_neg, r_alive, r_win;
  logic [SW-1:0]        r_step;
  logic [CW-1:0]        r_cnt;

  logic [AW-1:0]        w_cur_idx, w_nidx;
  logic [1:0]           w_dr, w_dc;
  logic [RW-1:0]        w_nr, w_nc;
  logic                 w_edge, w_hit, w_axis_win, w_win_total;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_accept, w_reject, w_do_move, w_walk_end, w_last;

  function automatic logic [1:0] flip_dir(input logic [1:0] d);
    return (d == D_P) ? D_M : ((d == D_M) ? D_P : D_0);
  endfunction

  assign w_cur_idx     = AW'(r_row) * AW'(N) + AW'(r_col);
  assign bus.cursor    = w_cur_idx;
  assign bus.rd_data   = ({1'b0, bus.rd_addr} < (AW+1)'(CELLS)) ? r_board[bus.rd_addr] : 2'b00;
  assign bus.turn      = r_turn;
  assign bus.busy      = r_busy;
  assign bus.place_err = r_place_err;
  assign bus.winner    = r_winner;
  assign bus.game_over = r_game_over;

  // axis order: horizontal, vertical, main diagonal, anti-diagonal
  always_comb begin
    w_dr = D_0;
    w_dc = D_P;
    case (r_axis)
      2'd0:    begin w_dr = D_0; w_dc = D_P; end
      2'd1:    begin w_dr = D_P; w_dc = D_0; end
      2'd2:    begin w_dr = D_P; w_dc = D_P; end
      default: begin w_dr = D_P; w_dc = D_M; end
    endcase
    if (r_neg) begin
      w_dr = flip_dir(w_dr);
      w_dc = flip_dir(w_dc);
    end
  end

  // one walk step: edge test before moving keeps row/col inside 0..N-1
  always_comb begin
    w_edge = ((w_dr == D_P) && (r_wr == RW'(N-1))) || ((w_dr == D_M) && (r_wr == '0)) ||
             ((w_dc == D_P) && (r_wc == RW'(N-1))) || ((w_dc == D_M) && (r_wc == '0));
    w_nr = r_wr;
    w_nc = r_wc;
    if (w_dr == D_P)      w_nr = r_wr + RW'(1);
    else if (w_dr == D_M) w_nr = r_wr - RW'(1);
    if (w_dc == D_P)      w_nc = r_wc + RW'(1);
    else if (w_dc == D_M) w_nc = r_wc - RW'(1);
    w_nidx      = w_edge ? '0 : (AW'(w_nr) * AW'(N) + AW'(w_nc));
    w_hit       = r_alive && !w_edge && (r_board[w_nidx] == r_mark);
    w_cnt_nxt   = r_cnt + CW'(w_hit);
    w_axis_win  = (w_cnt_nxt >= CW'(K));
    w_win_total = r_win || w_axis_win;
  end

  always_ff @(posedge clk) begin
    if (!resetn || bus.new_game) r_state <= S_PLAY;
    else                         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_do_move   = 1'b0;
    w_walk_end  = (r_step == SW'(K-2));
    w_last      = w_walk_end && r_neg && (r_axis == 2'd3);
    case (r_state)
      S_PLAY: begin
        if (bus.place) begin
          if (r_board[w_cur_idx] == 2'b00) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CHECK;
          end else begin
            w_reject = 1'b1;
          end
        end else if (bus.move_valid) begin
          w_do_move = 1'b1;
        end
      end
      S_CHECK: begin
        if (w_last)
          w_state_nxt = (w_win_total || (r_moves == MW'(CELLS))) ? S_OVER : S_PLAY;
      end
      S_OVER:  w_state_nxt = S_OVER;
      default: w_state_nxt = S_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn || bus.new_game) begin
      r_board     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_turn      <= 1'b0;
      r_moves     <= '0;
      r_winner    <= 2'b00;
      r_busy      <= 1'b0;
      r_place_err <= 1'b0;
      r_game_over <= 1'b0;
      r_mark      <= 2'b00;
      r_pr        <= '0;
      r_pc        <= '0;
      r_wr        <= '0;
      r_wc        <= '0;
      r_axis      <= '0;
      r_neg       <= 1'b0;
      r_alive     <= 1'b0;
      r_win       <= 1'b0;
      r_step      <= '0;
      r_cnt       <= '0;
    end else begin
      r_place_err <= w_reject;
      r_busy      <= (w_state_nxt == S_CHECK);
      if (w_do_move) begin
        case (bus.move_dir)
          2'b00:   if (r_row != '0)         r_row <= r_row - RW'(1);
          2'b01:   if (r_row != RW'(N-1))   r_row <= r_row + RW'(1);
          2'b10:   if (r_col != RW'(N-1))   r_col <= r_col + RW'(1);
          default: if (r_col != '0)         r_col <= r_col - RW'(1);
        endcase
      end
      if (w_accept) begin
        r_board[w_cur_idx] <= r_turn ? 2'b10 : 2'b01;
        r_mark  <= r_turn ? 2'b10 : 2'b01;
        r_moves <= r_moves + MW'(1);
        r_pr    <= r_row;
        r_pc    <= r_col;
        r_wr    <= r_row;
        r_wc    <= r_col;
        r_axis  <= '0;
        r_neg   <= 1'b0;
        r_step  <= '0;
        r_alive <= 1'b1;
        r_cnt   <= CW'(1);
        r_win   <= 1'b0;
      end
      // walks always spend their full budget; a stopped walk just stops counting
      if (r_state == S_CHECK) begin
        if (w_walk_end) begin
          r_step  <= '0;
          r_wr    <= r_pr;
          r_wc    <= r_pc;
          r_alive <= 1'b1;
          if (r_neg) begin
            r_neg  <= 1'b0;
            r_axis <= r_axis + 2'd1;
            r_cnt  <= CW'(1);
            r_win  <= w_win_total;
          end else begin
            r_neg  <= 1'b1;
            r_cnt  <= w_cnt_nxt;
          end
        end else begin
          r_step <= r_step + SW'(1);
          r_cnt  <= w_cnt_nxt;
          if (w_hit) begin
            r_wr <= w_nr;
            r_wc <= w_nc;
          end else begin
            r_alive <= 1'b0;
          end
        end
        if (w_last) begin
          if (w_win_total) begin
            r_winner    <= r_mark;
            r_game_over <= 1'b1;
          end else if (r_moves == MW'(CELLS)) begin
            r_winner    <= 2'b11;
            r_game_over <= 1'b1;
          end else begin
            r_turn <= ~r_turn;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_grid_game_ctrl.sv
// Bench for grid_game_ctrl: a 3x3/K=3 and a 5x5/K=4 instance against a board-scanning model.
module tb_grid_game_ctrl;
  logic clk = 1'b0;
  logic resetn;
  always #50 clk = ~clk;

  grid_game_if #(.N(3)) ifa ();
  grid_game_if #(.N(5)) ifb ();

  grid_game_ctrl #(.N(3), .K(3)) u_a (.clk(clk), .resetn(resetn), .bus(ifa.slave));
  grid_game_ctrl #(.N(5), .K(4)) u_b (.clk(clk), .resetn(resetn), .bus(ifb.slave));

  int n_tests = 0;
  int n_fail  = 0;

  int m_board [2][25];
  int m_row [2], m_col [2], m_turn [2], m_moves [2], m_winner [2];
  bit m_over [2];

  function automatic int mn(input int sel); return (sel == 0) ? 3 : 5; endfunction
  function automatic int mk(input int sel); return (sel == 0) ? 3 : 4; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_tests++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset(input int sel);
    for (int i = 0; i < 25; i++) m_board[sel][i] = 0;
    m_row[sel] = 0; m_col[sel] = 0; m_turn[sel] = 0;
    m_moves[sel] = 0; m_winner[sel] = 0; m_over[sel] = 1'b0;
  endtask

  // any K-long line of mark anywhere on the board
  function automatic bit line_win(input int sel, input int mark);
    int n, k, r, c;
    bit ok;
    int dr [4];
    int dc [4];
    n = mn(sel); k = mk(sel);
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int y = 0; y < n; y++)
      for (int x = 0; x < n; x++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int s = 0; s < k; s++) begin
            r = y + s*dr[d]; c = x + s*dc[d];
            if (r < 0 || r >= n || c < 0 || c >= n) ok = 1'b0;
            else if (m_board[sel][r*n+c] != mark) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input bit ng, input bit mv, input int md, input bit pl);
    if (sel == 0) begin
      ifa.new_game = ng; ifa.move_valid = mv; ifa.move_dir = 2'(md); ifa.place = pl;
    end else begin
      ifb.new_game = ng; ifb.move_valid = mv; ifb.move_dir = 2'(md); ifb.place = pl;
    end
  endtask

  task automatic get(input int sel, output logic [31:0] cur, output logic [31:0] trn,
                     output logic [31:0] bsy, output logic [31:0] perr,
                     output logic [31:0] win, output logic [31:0] go);
    if (sel == 0) begin
      cur = 32'(ifa.cursor); trn = 32'(ifa.turn); bsy = 32'(ifa.busy);
      perr = 32'(ifa.place_err); win = 32'(ifa.winner); go = 32'(ifa.game_over);
    end else begin
      cur = 32'(ifb.cursor); trn = 32'(ifb.turn); bsy = 32'(ifb.busy);
      perr = 32'(ifb.place_err); win = 32'(ifb.winner); go = 32'(ifb.game_over);
    end
  endtask

  task automatic read_cell(input int sel, input int idx, output logic [31:0] v);
    if (sel == 0) ifa.rd_addr = 4'(idx); else ifb.rd_addr = 5'(idx);
    #1;
    v = (sel == 0) ? 32'(ifa.rd_data) : 32'(ifb.rd_data);
  endtask

  task automatic chk_outs(input int sel, input string tag);
    logic [31:0] cur, trn, bsy, perr, win, go;
    get(sel, cur, trn, bsy, perr, win, go);
    chk($sformatf("%s_s%0d_cursor", tag, sel), cur, m_row[sel]*mn(sel) + m_col[sel]);
    chk($sformatf("%s_s%0d_turn", tag, sel), trn, m_turn[sel]);
    chk($sformatf("%s_s%0d_winner", tag, sel), win, m_winner[sel]);
    chk($sformatf("%s_s%0d_over", tag, sel), go, int'(m_over[sel]));
    chk($sformatf("%s_s%0d_busy", tag, sel), bsy, 0);
    chk($sformatf("%s_s%0d_perr", tag, sel), perr, 0);
  endtask

  task automatic chk_board(input int sel, input string tag);
    logic [31:0] v;
    for (int i = 0; i < mn(sel)*mn(sel); i++) begin
      read_cell(sel, i, v);
      chk($sformatf("%s_s%0d_cell%0d", tag, sel, i), v, m_board[sel][i]);
    end
  endtask

  task automatic do_move(input int sel, input int dir);
    drive(sel, 1'b0, 1'b1, dir, 1'b0);
    tick();
    drive(sel, 1'b0, 1'b0, 0, 1'b0);
    if (!m_over[sel]) begin
      case (dir)
        0: if (m_row[sel] > 0)           m_row[sel]--;
        1: if (m_row[sel] < mn(sel) - 1) m_row[sel]++;
        2: if (m_col[sel] < mn(sel) - 1) m_col[sel]++;
        default: if (m_col[sel] > 0)     m_col[sel]--;
      endcase
    end
    chk_outs(sel, "move");
  endtask

  task automatic goto(input int sel, input int idx);
    int tr, tc;
    tr = idx / mn(sel); tc = idx % mn(sel);
    while (m_row[sel] > tr) do_move(sel, 0);
    while (m_row[sel] < tr) do_move(sel, 1);
    while (m_col[sel] < tc) do_move(sel, 2);
    while (m_col[sel] > tc) do_move(sel, 3);
  endtask

  task automatic do_place(input int sel, input bit with_move);
    int n, idx, cnt;
    bit occ;
    logic [31:0] cur, trn, bsy, perr, win, go, v;
    n = mn(sel);
    idx = m_row[sel]*n + m_col[sel];
    occ = (m_board[sel][idx] != 0);
    drive(sel, 1'b0, with_move, int'($urandom_range(0, 3)), 1'b1);
    tick();
    drive(sel, 1'b0, 1'b0, 0, 1'b0);
    get(sel, cur, trn, bsy, perr, win, go);
    if (m_over[sel]) begin
      chk_outs(sel, "over_hold");
    end else if (occ) begin
      chk("err_pulse_hi", perr, 1);
      chk("err_busy", bsy, 0);
      chk("err_cursor", cur, idx);
      chk("err_turn", trn, m_turn[sel]);
      tick();
      get(sel, cur, trn, bsy, perr, win, go);
      chk("err_pulse_lo", perr, 0);
    end else begin
      m_board[sel][idx] = m_turn[sel] + 1;
      m_moves[sel]++;
      chk("busy_rise", bsy, 1);
      chk("place_cursor", cur, idx);
      read_cell(sel, idx, v);
      chk("rd_after_write", v, m_board[sel][idx]);
      cnt = 0;
      while (bsy === 1'b1 && cnt < 100) begin
        cnt++;
        drive(sel, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        tick();
        get(sel, cur, trn, bsy, perr, win, go);
        chk("check_no_perr", perr, 0);
      end
      drive(sel, 1'b0, 1'b0, 0, 1'b0);
      chk($sformatf("check_len_s%0d", sel), cnt, 8*(mk(sel) - 1));
      if (line_win(sel, m_turn[sel] + 1)) begin
        m_winner[sel] = m_turn[sel] + 1; m_over[sel] = 1'b1;
      end else if (m_moves[sel] == n*n) begin
        m_winner[sel] = 3; m_over[sel] = 1'b1;
      end else begin
        m_turn[sel] ^= 1;
      end
      chk_outs(sel, "after_check");
    end
  endtask

  task automatic new_game(input int sel);
    drive(sel, 1'b1, 1'b0, 0, 1'b0);
    tick();
    drive(sel, 1'b0, 1'b0, 0, 1'b0);
    model_reset(sel);
    chk_outs(sel, "new_game");
  endtask

  task automatic play_seq(input int sel, input int seq [$]);
    new_game(sel);
    foreach (seq[i]) begin
      goto(sel, seq[i]);
      do_place(sel, 1'b0);
    end
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur, trn, bsy, perr, win, go, v;
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 1'b0);
    ifa.rd_addr = '0; ifb.rd_addr = '0;
    model_reset(0); model_reset(1);
    tick(); tick();
    resetn = 1'b1;
    chk_outs(0, "reset"); chk_outs(1, "reset");
    chk_board(0, "reset"); chk_board(1, "reset");

    // cursor saturation
    do_move(0, 0); do_move(0, 3);
    get(0, cur, trn, bsy, perr, win, go); chk("sat_corner", cur, 0);
    repeat (3) do_move(0, 2);
    get(0, cur, trn, bsy, perr, win, go); chk("sat_right", cur, 2);
    repeat (3) do_move(0, 1);
    get(0, cur, trn, bsy, perr, win, go); chk("sat_bottom", cur, 8);

    // row win, then OVER must ignore commands
    play_seq(0, '{0, 3, 1, 4, 2});
    get(0, cur, trn, bsy, perr, win, go);
    chk("row_win_winner", win, 1); chk("row_win_over", go, 1);
    do_move(0, 1);
    do_place(0, 1'b0);
    chk_board(0, "over_board");

    // occupied cell
    new_game(0);
    goto(0, 4); do_place(0, 1'b0); do_place(0, 1'b1);
    read_cell(0, 4, v); chk("occ_cell4", v, 1);
    get(0, cur, trn, bsy, perr, win, go); chk("occ_turn", trn, 1);

    // draw, and last-cell diagonal win
    play_seq(0, '{0, 1, 2, 4, 3, 5, 7, 6, 8});
    get(0, cur, trn, bsy, perr, win, go); chk("draw_winner", win, 3);
    chk_board(0, "draw");
    play_seq(0, '{0, 1, 2, 5, 3, 6, 8, 7, 4});
    get(0, cur, trn, bsy, perr, win, go); chk("lastcell_win", win, 1);

    // 5x5 K=4: P0 builds a 3-long column, P1 the anti-diagonal
    play_seq(1, '{0, 3, 5, 7, 10});
    get(1, cur, trn, bsy, perr, win, go); chk("three_long_nowin", win, 0);
    play_seq(1, '{0, 3, 5, 7, 10, 11, 24, 15});
    get(1, cur, trn, bsy, perr, win, go);
    chk("anti_diag_winner", win, 2); chk("anti_diag_over", go, 1);
    chk_board(1, "anti_diag");

    // clear during the fifth CHECK cycle
    new_game(0);
    goto(0, 4);
    drive(0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) tick();
    get(0, cur, trn, bsy, perr, win, go); chk("mid_check_busy", bsy, 1);
    drive(0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 0, 1'b0);
    model_reset(0);
    chk_outs(0, "mid_clear");
    chk_board(0, "mid_clear");
    do_move(0, 2);

    // random play on both boards
    for (int g = 0; g < 6; g++) begin
      int sel;
      sel = g % 2;
      new_game(sel);
      for (int a = 0; a < 50; a++) begin
        if ($urandom_range(0, 9) < 6) do_move(sel, int'($urandom_range(0, 3)));
        else do_place(sel, 1'($urandom_range(0, 1)));
      end
      chk_board(sel, "random");
    end

    // reset with new_game asserted together
    resetn = 1'b0;
    drive(0, 1'b1, 1'b0, 0, 1'b0);
    drive(1, 1'b1, 1'b0, 0, 1'b0);
    tick();
    resetn = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 1'b0);
    model_reset(0); model_reset(1);
    chk_outs(0, "rst_ng"); chk_outs(1, "rst_ng");
    chk_board(0, "rst_ng"); chk_board(1, "rst_ng");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/grid_game_ctrl.md
GRID_GAME_CTRL -- requirements
Module: grid_game_ctrl

Interface
REQ-001 Parameter N, default 3: board side length, cells N*N, N >= 3.
REQ-002 Parameter K, default 3: line length needed to win, 3 <= K <= N.
REQ-003 clk  input  1  clock, all state updates on posedge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 new_game  input  1  synchronous clear of the board and game state, accepted in any state.
REQ-006 move_valid  input  1  one-cycle request to move the cursor one cell.
REQ-007 move_dir  input  2  direction: 00 up, 01 down, 10 right, 11 left.
REQ-008 place  input  1  one-cycle request to put the current player's mark at the cursor.
REQ-009 rd_addr  input  clog2(N*N)  combinational cell read address, row-major (row*N+col).
REQ-010 rd_data  output  2  cell contents at rd_addr: 00 empty, 01 player 0, 10 player 1.
REQ-011 cursor  output  clog2(N*N)  current cursor cell index, row-major.
REQ-012 turn  output  1  player to move, 0 or 1.
REQ-013 busy  output  1  high while in CHECK.
REQ-014 place_err  output  1  one-cycle pulse when a place request is rejected.
REQ-015 winner  output  2  00 undecided, 01 player 0, 10 player 1, 11 draw.
REQ-016 game_over  output  1  high in OVER.

Function
REQ-017 The FSM SHALL have the states PLAY, CHECK and OVER.
REQ-018 PLAY: on move_valid the cursor SHALL move one cell in move_dir and saturate at the board edges, with no wrap-around.
REQ-019 PLAY: on place with an empty cursor cell, the cell SHALL get the code for turn; the move count increments; the FSM goes to CHECK on the next cycle.
REQ-020 PLAY: on place with an occupied cell, the board SHALL stay unchanged, place_err pulses for 1 cycle and the FSM stays in PLAY.
REQ-021 PLAY: if place and move_valid arrive in the same cycle, place SHALL win and the move is dropped.
REQ-022 CHECK: the FSM SHALL test 4 axes in fixed order: horizontal, vertical, main diagonal, anti-diagonal.
REQ-023 CHECK, per axis: walk the positive direction for exactly K-1 cycles, then the negative direction for exactly K-1 cycles.
REQ-024 CHECK, counting: count consecutive cells equal to the placed mark, starting from the placed cell.
REQ-025 CHECK, stop rule: a walk stops counting at the board edge or at a mismatch, but still uses its full cycle budget.
REQ-026 CHECK SHALL last exactly 8*(K-1) cycles whatever the board contents, so latency is fixed.
REQ-027 Leaving CHECK with a win: if any axis count (including the placed cell) is >= K, winner SHALL become 01 or 10 for the player who placed, and the FSM goes to OVER.
REQ-028 Leaving CHECK with no win and a full board (move count == N*N): winner SHALL become 11 and the FSM goes to OVER.
REQ-029 Leaving CHECK otherwise: turn SHALL toggle and the FSM returns to PLAY.
REQ-030 A win on the last empty cell SHALL report the winner, not a draw.
REQ-031 move_valid and place SHALL be ignored in CHECK and OVER, and place_err stays 0 there.
REQ-032 OVER SHALL hold the board, winner and cursor until new_game or reset.
REQ-033 new_game, including mid-CHECK, SHALL have the same effect as reset on the next cycle.
REQ-034 The move counter SHALL be clog2(N*N+1) bits wide; row and column arithmetic SHALL never index outside 0..N-1.
REQ-035 rd_data SHALL show a write made by place from the cycle after the write.

Reset
REQ-036 When resetn is low at posedge, the block SHALL set: all cells 00, cursor 0, turn 0, move count 0, winner 00, busy 0, place_err 0, game_over 0, state PLAY.
REQ-037 When resetn and new_game are both asserted, reset SHALL take priority; the result is the same.

Verification
REQ-038 Cursor saturation (N=3, K=3): reset, then up, then left -> cursor 0; then right x3 -> cursor 2; then down x3 -> cursor 8.
REQ-039 Row win (N=3, K=3): P0 places 0, 1, 2 and P1 places 3, 4, alternating -> after the placement at 2, busy high for 16 cycles, then winner 01, game_over 1.
REQ-040 Occupied cell: P0 places 4, then P1 tries to place at 4 -> place_err pulses once, rd_data(4)=01, turn stays 1.
REQ-041 Draw: play the 9-move sequence 0,1,2,4,3,5,7,6,8 -> winner 11 after the final CHECK; the same board with the final move making a diagonal gives 01.
REQ-042 Generalised board (N=5, K=4): P1 completes the anti-diagonal cells 3, 7, 11, 15 -> CHECK lasts 24 cycles, winner 10; a 3-long line gives no win.
REQ-043 Mid-check clear: assert new_game during cycle 5 of CHECK -> next cycle all cells 00, state PLAY, winner 00, turn 0.
